pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline. It owns the PC hold (hazard_pc) and the
//  IF/ID, ID/EX, EX/MEM and MEM/WB enables/bubbles. It arbitrates four sources: start-up boot,

---
 rtl/pipe_hazard_ctrl_pkg.sv | 44 ++++
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall scheduler.
// Contents: scheduler state encoding, register-address width, and the
// control-bundle constants (NOP/bubble and the fixed hold patterns).
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BOOT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_hold;
        logic memwb_bubble;
    } ctrl_t;

    // Nothing held, nothing bubbled: the pipeline advances freely.
    localparam ctrl_t CTRL_NOP = '0;

    // Fetch blocked: PC frozen and IF/ID fed with NOPs (IDLE and BOOT).
    localparam ctrl_t CTRL_FETCH_OFF = '{pc_hold: 1'b1, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                         idex_bubble: 1'b0, exmem_hold: 1'b0, memwb_bubble: 1'b0};

    // Load-use: freeze the front end, inject one bubble into EX.
    localparam ctrl_t CTRL_LOAD_USE = '{pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                        idex_bubble: 1'b1, exmem_hold: 1'b0, memwb_bubble: 1'b0};

    // Memory wait / fault: everything up to MEM frozen, WB receives bubbles.
    localparam ctrl_t CTRL_MEM_HOLD = '{pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                        idex_bubble: 1'b0, exmem_hold: 1'b1, memwb_bubble: 1'b1};

    // Taken branch/jump: squash the wrong-path fetch in IF/ID only.
    localparam ctrl_t CTRL_FLUSH = '{pc_hold: 1'b0, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                     idex_bubble: 1'b0, exmem_hold: 1'b0, memwb_bubble: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stall/flush controls and
// status/performance counters out.
// Modports: master = pipeline/top side (drives *_i), slave = controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_hazard_ctrl_pkg::*;

    logic              start_i;
    logic              idex_memread_i;
    logic [REG_AW-1:0] idex_rt_i;
    logic [REG_AW-1:0] ifid_rs_i;
    logic [REG_AW-1:0] ifid_rt_i;
    logic              ifid_use_rt_i;
    logic              branch_taken_i;
    logic              jump_i;
    logic              dmem_req_i;
    logic              dmem_ack_i;
    logic              pc_hold_o;
    logic              ifid_hold_o;
    logic              ifid_flush_o;
    logic              idex_bubble_o;
    logic              exmem_hold_o;
    logic              memwb_bubble_o;
    logic              running_o;
    logic              fault_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_use_rt_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        input  pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, exmem_hold_o,
               memwb_bubble_o, running_o, fault_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_use_rt_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        output pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, exmem_hold_o,
               memwb_bubble_o, running_o, fault_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc_i=1, sticks at all-ones.
// Ports: clk_i, rst_i (async, active-high, clears to 0), inc_i, cnt_o[W].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Arbitrates boot, memory wait, load-use and branch/jump flush; keeps a
// sticky memory-timeout fault and saturating stall/flush counters.
// Ports: clk_i, rst_i (async, active-high), bus (pipe_hazard_ctrl_if.slave).
// Control outputs are combinational from state + inputs for same-cycle stall.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [BOOT_W-1:0] boot_q, boot_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    ctrl_t             ctrl;
    logic              load_use;
    logic              mem_stall;
    logic              stall_inc;
    logic              flush_inc;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // $0 is hardwired zero, so a load into it never creates a dependency.
    assign load_use = bus.idex_memread_i && (bus.idex_rt_i != '0) &&
                      ((bus.idex_rt_i == bus.ifid_rs_i) ||
                       (bus.ifid_use_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));
    assign mem_stall = bus.dmem_req_i && !bus.dmem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            boot_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        boot_d  = boot_q;
        tmo_d   = tmo_q;
        ctrl    = CTRL_NOP;
        unique case (state_q)
            ST_IDLE: begin
                ctrl = CTRL_FETCH_OFF;
                if (bus.start_i) begin
                    state_d = ST_BOOT;
                    boot_d  = BOOT_LOAD;
                end
            end
            ST_BOOT: begin
                ctrl = CTRL_FETCH_OFF;
                if (!bus.start_i) begin
                    state_d = ST_IDLE;
                end else if (boot_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_d = boot_q - BOOT_W'(1);
                end
            end
            ST_RUN: begin
                // A branch colliding with a load-use stall is dropped here;
                // ID still holds it and resolves it again next cycle.
                if (mem_stall) begin
                    ctrl    = CTRL_MEM_HOLD;
                    state_d = ST_MEMWAIT;
                    tmo_d   = TMO_W'(1);
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end else if (bus.branch_taken_i || bus.jump_i) begin
                    ctrl = CTRL_FLUSH;
                end
                if (!bus.start_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEMWAIT: begin
                // Ack is checked before the limit so a late ack still wins.
                if (bus.dmem_ack_i) begin
                    state_d = bus.start_i ? ST_RUN : ST_IDLE;
                end else begin
                    ctrl = CTRL_MEM_HOLD;
                    if (tmo_q == TMO_LIMIT) begin
                        state_d = ST_FAULT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                ctrl = CTRL_MEM_HOLD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stall_inc = ctrl.pc_hold && ((state_q == ST_RUN) || (state_q == ST_MEMWAIT));
    assign flush_inc = ctrl.ifid_flush && (state_q == ST_RUN);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );

    assign bus.pc_hold_o      = ctrl.pc_hold;
    assign bus.ifid_hold_o    = ctrl.ifid_hold;
    assign bus.ifid_flush_o   = ctrl.ifid_flush;
    assign bus.idex_bubble_o  = ctrl.idex_bubble;
    assign bus.exmem_hold_o   = ctrl.exmem_hold;
    assign bus.memwb_bubble_o = ctrl.memwb_bubble;
    assign bus.running_o      = (state_q == ST_RUN);
    assign bus.fault_o        = (state_q == ST_FAULT);
    assign bus.stall_cnt_o    = stall_cnt;
    assign bus.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. dut_a uses default sizing
// (BOOT_CYCLES=2, MEM_TIMEOUT=255, CNT_W=16); dut_b uses MEM_TIMEOUT=4,
// CNT_W=2 for the timeout, fault and counter-saturation scenarios.
// Control vector order: {pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble}.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  ifb ();

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (ifa)
    );

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    logic [5:0] ctl_a;
    logic [5:0] ctl_b;
    assign ctl_a = {ifa.pc_hold_o, ifa.ifid_hold_o, ifa.ifid_flush_o,
                    ifa.idex_bubble_o, ifa.exmem_hold_o, ifa.memwb_bubble_o};
    assign ctl_b = {ifb.pc_hold_o, ifb.ifid_hold_o, ifb.ifid_flush_o,
                    ifb.idex_bubble_o, ifb.exmem_hold_o, ifb.memwb_bubble_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.start_i = 0; ifa.idex_memread_i = 0; ifa.idex_rt_i = 0; ifa.ifid_rs_i = 0;
        ifa.ifid_rt_i = 0; ifa.ifid_use_rt_i = 0; ifa.branch_taken_i = 0; ifa.jump_i = 0;
        ifa.dmem_req_i = 0; ifa.dmem_ack_i = 0;
        ifb.start_i = 0; ifb.idex_memread_i = 0; ifb.idex_rt_i = 0; ifb.ifid_rs_i = 0;
        ifb.ifid_rt_i = 0; ifb.ifid_use_rt_i = 0; ifb.branch_taken_i = 0; ifb.jump_i = 0;
        ifb.dmem_req_i = 0; ifb.dmem_ack_i = 0;
    endtask

    task automatic boot_b();
        ifb.start_i = 1;
        step(); step(); step();
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1;
        clear_inputs();
        #2;
        n_tests++; if (ctl_a !== 6'b101000) begin n_fail++; $display("FAIL reset_ctl_a got %b want 101000", ctl_a); end
        n_tests++; if (ctl_b !== 6'b101000) begin n_fail++; $display("FAIL reset_ctl_b got %b want 101000", ctl_b); end
        n_tests++; if ({ifa.running_o, ifa.fault_o} !== 2'b00) begin n_fail++; $display("FAIL reset_status got %b want 00", {ifa.running_o, ifa.fault_o}); end
        n_tests++; if (ifa.stall_cnt_o !== 16'd0 || ifa.flush_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", ifa.stall_cnt_o, ifa.flush_cnt_o); end
        step();
        rst_a = 0; rst_b = 0;
    endtask

    task automatic test_boot();
        ifa.start_i = 1;
        #1;
        n_tests++; if (ctl_a !== 6'b101000 || ifa.running_o !== 1'b0) begin n_fail++; $display("FAIL boot_c0 got %b/%b want 101000/0", ctl_a, ifa.running_o); end
        for (int c = 1; c <= 2; c++) begin
            step();
            n_tests++; if (ctl_a !== 6'b101000 || ifa.running_o !== 1'b0) begin n_fail++; $display("FAIL boot_c%0d got %b/%b want 101000/0", c, ctl_a, ifa.running_o); end
        end
        step();
        n_tests++; if (ctl_a !== 6'b000000 || ifa.running_o !== 1'b1) begin n_fail++; $display("FAIL boot_c3 got %b/%b want 000000/1", ctl_a, ifa.running_o); end
        n_tests++; if (ifa.stall_cnt_o !== 16'd0 || ifa.flush_cnt_o !== 16'd0) begin n_fail++; $display("FAIL boot_counters got %0d/%0d want 0/0", ifa.stall_cnt_o, ifa.flush_cnt_o); end
    endtask

    task automatic test_load_use();
        // lw $2 in EX, add $3,$2,$4 in ID
        ifa.idex_memread_i = 1; ifa.idex_rt_i = 2; ifa.ifid_rs_i = 2; ifa.ifid_rt_i = 4; ifa.ifid_use_rt_i = 1;
        #1;
        n_tests++; if (ctl_a !== 6'b110100) begin n_fail++; $display("FAIL lu_rs got %b want 110100", ctl_a); end
        step();
        ifa.idex_memread_i = 0;
        #1;
        n_tests++; if (ctl_a !== 6'b000000) begin n_fail++; $display("FAIL lu_release got %b want 000000", ctl_a); end
        n_tests++; if (ifa.stall_cnt_o !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", ifa.stall_cnt_o); end
        // match through rt only
        ifa.idex_memread_i = 1; ifa.idex_rt_i = 2; ifa.ifid_rs_i = 3; ifa.ifid_rt_i = 2; ifa.ifid_use_rt_i = 1;
        #1;
        n_tests++; if (ctl_a !== 6'b110100) begin n_fail++; $display("FAIL lu_rt got %b want 110100", ctl_a); end
        step();
        ifa.ifid_use_rt_i = 0;
        #1;
        n_tests++; if (ctl_a !== 6'b000000) begin n_fail++; $display("FAIL lu_rt_unused got %b want 000000", ctl_a); end
        // load into $0 never stalls
        ifa.idex_rt_i = 0; ifa.ifid_rs_i = 0; ifa.ifid_rt_i = 0; ifa.ifid_use_rt_i = 1;
        #1;
        n_tests++; if (ctl_a !== 6'b000000) begin n_fail++; $display("FAIL lu_r0 got %b want 000000", ctl_a); end
        step();
        ifa.idex_memread_i = 0; ifa.ifid_use_rt_i = 0;
        #1;
        n_tests++; if (ifa.stall_cnt_o !== 16'd2) begin n_fail++; $display("FAIL lu_stall_total got %0d want 2", ifa.stall_cnt_o); end
    endtask

    task automatic test_memwait();
        ifa.dmem_req_i = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++; if (ctl_a !== 6'b110011 || ifa.fault_o !== 1'b0) begin n_fail++; $display("FAIL mw_hold_%0d got %b/%b want 110011/0", i, ctl_a, ifa.fault_o); end
            step();
        end
        ifa.dmem_ack_i = 1;
        #1;
        n_tests++; if (ctl_a !== 6'b000000) begin n_fail++; $display("FAIL mw_ack_cycle got %b want 000000", ctl_a); end
        step();
        ifa.dmem_req_i = 0; ifa.dmem_ack_i = 0;
        #1;
        n_tests++; if (ifa.running_o !== 1'b1 || ifa.fault_o !== 1'b0) begin n_fail++; $display("FAIL mw_after got run=%b fault=%b want 1/0", ifa.running_o, ifa.fault_o); end
        n_tests++; if (ifa.stall_cnt_o !== 16'd7) begin n_fail++; $display("FAIL mw_stall_cnt got %0d want 7", ifa.stall_cnt_o); end
    endtask

    task automatic test_branch_vs_load_use();
        ifa.branch_taken_i = 1; ifa.idex_memread_i = 1; ifa.idex_rt_i = 2; ifa.ifid_rs_i = 2;
        #1;
        n_tests++; if (ctl_a !== 6'b110100) begin n_fail++; $display("FAIL br_lu_same got %b want 110100", ctl_a); end
        step();
        ifa.idex_memread_i = 0;
        #1;
        n_tests++; if (ctl_a !== 6'b001000) begin n_fail++; $display("FAIL br_retry got %b want 001000", ctl_a); end
        step();
        ifa.branch_taken_i = 0;
        #1;
        n_tests++; if (ifa.flush_cnt_o !== 16'd1 || ifa.stall_cnt_o !== 16'd8) begin n_fail++; $display("FAIL br_counts got %0d/%0d want 1/8", ifa.flush_cnt_o, ifa.stall_cnt_o); end
        ifa.jump_i = 1;
        #1;
        n_tests++; if (ctl_a !== 6'b001000) begin n_fail++; $display("FAIL jump_flush got %b want 001000", ctl_a); end
        step();
        ifa.jump_i = 0;
        #1;
        n_tests++; if (ifa.flush_cnt_o !== 16'd2) begin n_fail++; $display("FAIL jump_cnt got %0d want 2", ifa.flush_cnt_o); end
    endtask

    task automatic test_stop_run();
        ifa.start_i = 0;
        #1;
        n_tests++; if (ctl_a !== 6'b000000 || ifa.running_o !== 1'b1) begin n_fail++; $display("FAIL stop_c0 got %b/%b want 000000/1", ctl_a, ifa.running_o); end
        step();
        n_tests++; if (ctl_a !== 6'b101000 || ifa.running_o !== 1'b0) begin n_fail++; $display("FAIL stop_idle got %b/%b want 101000/0", ctl_a, ifa.running_o); end
        step();
        n_tests++; if (ifa.flush_cnt_o !== 16'd2 || ifa.stall_cnt_o !== 16'd8) begin n_fail++; $display("FAIL stop_counts got %0d/%0d want 2/8", ifa.flush_cnt_o, ifa.stall_cnt_o); end
    endtask

    task automatic test_ack_at_limit();
        boot_b();
        n_tests++; if (ifb.running_o !== 1'b1) begin n_fail++; $display("FAIL b_boot got %b want 1", ifb.running_o); end
        ifb.dmem_req_i = 1;
        step(); step(); step(); step();
        ifb.dmem_ack_i = 1;
        #1;
        n_tests++; if (ctl_b !== 6'b000000 || ifb.fault_o !== 1'b0) begin n_fail++; $display("FAIL limit_ack got %b/%b want 000000/0", ctl_b, ifb.fault_o); end
        step();
        ifb.dmem_req_i = 0; ifb.dmem_ack_i = 0;
        #1;
        n_tests++; if (ifb.running_o !== 1'b1 || ifb.fault_o !== 1'b0) begin n_fail++; $display("FAIL limit_after got run=%b fault=%b want 1/0", ifb.running_o, ifb.fault_o); end
        n_tests++; if (ifb.stall_cnt_o !== 2'd3) begin n_fail++; $display("FAIL sat_stall got %0d want 3", ifb.stall_cnt_o); end
    endtask

    task automatic test_fault();
        ifb.dmem_req_i = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++; if (ctl_b !== 6'b110011 || ifb.fault_o !== 1'b0) begin n_fail++; $display("FAIL to_wait_%0d got %b/%b want 110011/0", i, ctl_b, ifb.fault_o); end
            step();
        end
        n_tests++; if (ifb.fault_o !== 1'b1 || ifb.running_o !== 1'b0 || ctl_b !== 6'b110011) begin n_fail++; $display("FAIL to_fault got f=%b r=%b ctl=%b want 1/0/110011", ifb.fault_o, ifb.running_o, ctl_b); end
        ifb.dmem_req_i = 0; ifb.dmem_ack_i = 1; ifb.start_i = 0;
        step();
        ifb.dmem_ack_i = 0;
        step();
        n_tests++; if (ifb.fault_o !== 1'b1 || ctl_b !== 6'b110011) begin n_fail++; $display("FAIL to_sticky got %b/%b want 1/110011", ifb.fault_o, ctl_b); end
        n_tests++; if (ifb.stall_cnt_o !== 2'd3) begin n_fail++; $display("FAIL sat_hold got %0d want 3", ifb.stall_cnt_o); end
        rst_b = 1;
        #1;
        n_tests++; if (ifb.fault_o !== 1'b0 || ifb.stall_cnt_o !== 2'd0) begin n_fail++; $display("FAIL to_reset got f=%b cnt=%0d want 0/0", ifb.fault_o, ifb.stall_cnt_o); end
        step();
        rst_b = 0;
    endtask

    task automatic test_reset_mid_memwait();
        boot_b();
        ifb.dmem_req_i = 1;
        step();
        n_tests++; if (ctl_b !== 6'b110011 || ifb.stall_cnt_o !== 2'd1) begin n_fail++; $display("FAIL mid_pre got %b/%0d want 110011/1", ctl_b, ifb.stall_cnt_o); end
        #2;
        rst_b = 1;
        #1;
        n_tests++; if (ctl_b !== 6'b101000 || ifb.running_o !== 1'b0 || ifb.fault_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state got %b r=%b f=%b want 101000/0/0", ctl_b, ifb.running_o, ifb.fault_o); end
        n_tests++; if (ifb.stall_cnt_o !== 2'd0 || ifb.flush_cnt_o !== 2'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", ifb.stall_cnt_o, ifb.flush_cnt_o); end
        step();
        rst_b = 0;
        ifb.dmem_req_i = 0; ifb.start_i = 0;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_load_use();
        test_memwait();
        test_branch_vs_load_use();
        test_stop_run();
        test_ack_at_limit();
        test_fault();
        test_reset_mid_memwait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
